// File: rtl/block_map_pkg.sv
// Shared definitions for the arena block map: cell codes, FSM states,
// arena geometry, generator polynomial and the spawn-safe corner rule.
package block_map_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY  = 2'b00,
    CELL_SOFT   = 2'b01,
    CELL_PILLAR = 2'b10
  } cell_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_CLR_CHK,
    ST_Q_RSP
  } state_e;

  localparam int MAP_W     = 33;
  localparam int MAP_H     = 26;
  localparam int MAP_CELLS = MAP_W * MAP_H;

  // x^16 + x^14 + x^13 + x^11 + 1 as a Fibonacci tap mask on bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Spawn corner (0,0),(1,0),(0,1) is always kept clear: Manhattan radius 1.
  localparam int SPAWN_RADIUS = 1;

  function automatic logic is_spawn(input logic [5:0] x, input logic [4:0] y);
    return (7'(x) + 7'(y)) <= 7'(SPAWN_RADIUS);
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/block_map_if.sv
// Client-facing bus of the block map: explosion clear requests and
// tile-collision queries.
interface block_map_if;
  logic [9:0] clr_addr;
  logic       clr_we;
  logic [5:0] q_x;
  logic [5:0] q_y;
  logic       q_req;
  logic       q_valid;
  logic       q_blocked;

  modport master (output clr_addr, clr_we, q_x, q_y, q_req,
                  input  q_valid, q_blocked);
  modport slave  (input  clr_addr, clr_we, q_x, q_y, q_req,
                  output q_valid, q_blocked);
endinterface

// File: rtl/block_map_ram.sv
// 1024x2 true dual-port synchronous RAM; port A read-only, port B read/write,
// both with a registered read.
module block_map_ram (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] addr_a,
  output logic [1:0] dout_a,
  input  logic [9:0] addr_b,
  input  logic       we_b,
  input  logic [1:0] din_b,
  output logic [1:0] dout_b
);

  logic [1:0] mem [1024];

  // NOTE: the array has no reset so it maps onto block RAM; INIT rewrites
  // every live cell before the map is ever served.
  always_ff @(posedge clk) begin
    if (we_b) mem[addr_b] <= din_b;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_a <= 2'b00;
      dout_b <= 2'b00;
    end else begin
      dout_a <= mem[addr_a];
      dout_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/block_map.sv
// Arena block map: procedural level generation, pixel display read port,
// deduplicating clear FIFO with read-modify-write service, collision queries.
module block_map
  import block_map_pkg::*;
#(
  parameter int          MAP_W     = block_map_pkg::MAP_W,
  parameter int          MAP_H     = block_map_pkg::MAP_H,
  parameter logic [7:0]  DENSITY   = 8'd96,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regen,
  input  logic [9:0]  x_a,
  input  logic [9:0]  y_a,
  output logic [1:0]  pix_code,
  block_map_if.slave  bus,
  output logic        ready,
  output logic [9:0]  blocks_left,
  output logic        clr_overflow
);

  localparam int N_CELLS = MAP_W * MAP_H;

  state_e      state, state_nxt;
  logic [9:0]  init_addr;
  logic [5:0]  init_x;
  logic [4:0]  init_y;
  logic [15:0] lfsr;
  cell_e       init_code;

  logic [9:0]  fifo_mem [4];
  logic [1:0]  fifo_rd, fifo_wr;
  logic [2:0]  fifo_cnt;
  logic [9:0]  last_addr;
  logic        last_vld;
  logic [9:0]  clr_cur;
  logic        q_oob_r;

  logic [9:0]  pix_addr, pix_lin, q_lin;
  logic [9:0]  b_addr;
  logic        b_we;
  logic [1:0]  b_din, b_dout;
  logic        fifo_pop, q_take, do_regen, soft_hit;
  logic        clr_req, push_ok, drop, q_oob;
  logic        unused_sub_tile;

  // Sub-tile pixel bits select nothing; only the 16-pixel tile index matters.
  assign unused_sub_tile = ^{x_a[3:0], y_a[3:0]};
  assign pix_lin = 10'(y_a[9:4]) * 10'(MAP_W) + 10'(x_a[9:4]);
  assign q_lin   = 10'(bus.q_y) * 10'(MAP_W) + 10'(bus.q_x);
  assign q_oob   = (bus.q_x > 6'(MAP_W - 1)) || (bus.q_y > 6'(MAP_H - 1));

  // A held enable re-presenting the same address is one request, not many.
  assign clr_req = bus.clr_we && (bus.clr_addr < 10'(N_CELLS)) &&
                   !(last_vld && bus.clr_addr == last_addr);
  assign push_ok = clr_req && (fifo_cnt != 3'd4 || fifo_pop);
  assign drop    = clr_req && fifo_cnt == 3'd4 && !fifo_pop;

  always_comb begin
    if (init_x[0] && init_y[0])   init_code = CELL_PILLAR;
    else if (is_spawn(init_x, init_y)) init_code = CELL_EMPTY;
    else if (lfsr[7:0] < DENSITY) init_code = CELL_SOFT;
    else                          init_code = CELL_EMPTY;
  end

  block_map_ram u_ram (
    .clk    (clk),
    .reset  (reset),
    .addr_a (pix_addr),
    .dout_a (pix_code),
    .addr_b (b_addr),
    .we_b   (b_we),
    .din_b  (b_din),
    .dout_b (b_dout)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    b_addr    = init_addr;
    b_we      = 1'b0;
    b_din     = init_code;
    fifo_pop  = 1'b0;
    q_take    = 1'b0;
    do_regen  = 1'b0;
    soft_hit  = 1'b0;
    unique case (state)
      ST_INIT: begin
        b_we = 1'b1;
        if (init_addr == 10'(N_CELLS - 1)) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (regen) begin
          do_regen  = 1'b1;
          state_nxt = ST_INIT;
        end else if (fifo_cnt != 3'd0) begin
          fifo_pop  = 1'b1;
          b_addr    = fifo_mem[fifo_rd];
          state_nxt = ST_CLR_CHK;
        end else if (bus.q_req) begin
          q_take    = 1'b1;
          if (!q_oob) b_addr = q_lin;
          state_nxt = ST_Q_RSP;
        end
      end
      ST_CLR_CHK: begin
        b_addr = clr_cur;
        if (b_dout == CELL_SOFT) begin
          b_we     = 1'b1;
          b_din    = CELL_EMPTY;
          soft_hit = 1'b1;
        end
        state_nxt = ST_IDLE;
      end
      ST_Q_RSP: state_nxt = ST_IDLE;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok && !do_regen) fifo_mem[fifo_wr] <= bus.clr_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      init_addr <= '0;  init_x <= '0;  init_y <= '0;
      lfsr      <= LFSR_SEED;
      fifo_rd   <= '0;  fifo_wr <= '0;  fifo_cnt <= '0;
      last_addr <= '0;  last_vld <= 1'b0;
      clr_cur   <= '0;  q_oob_r <= 1'b0;
      pix_addr  <= '0;
      bus.q_valid   <= 1'b0;
      bus.q_blocked <= 1'b0;
      ready         <= 1'b0;
      blocks_left   <= '0;
      clr_overflow  <= 1'b0;
    end else begin
      pix_addr    <= pix_lin;
      bus.q_valid <= 1'b0;

      if (state == ST_INIT) begin
        lfsr      <= lfsr_next(lfsr);
        init_addr <= init_addr + 10'd1;
        if (init_x == 6'(MAP_W - 1)) begin
          init_x <= '0;
          init_y <= init_y + 5'd1;
        end else begin
          init_x <= init_x + 6'd1;
        end
        if (init_code == CELL_SOFT) blocks_left <= blocks_left + 10'd1;
      end

      if (soft_hit) blocks_left <= blocks_left - 10'd1;
      if (fifo_pop) clr_cur <= fifo_mem[fifo_rd];
      if (q_take)   q_oob_r <= q_oob;
      if (state == ST_Q_RSP) begin
        bus.q_valid   <= 1'b1;
        bus.q_blocked <= q_oob_r || (b_dout != CELL_EMPTY);
      end

      if (!bus.clr_we) begin
        last_vld <= 1'b0;
      end else if (clr_req) begin
        last_vld  <= 1'b1;
        last_addr <= bus.clr_addr;
      end

      if (do_regen) begin
        init_addr <= '0;  init_x <= '0;  init_y <= '0;
        lfsr      <= LFSR_SEED;
        fifo_rd   <= '0;  fifo_wr <= '0;  fifo_cnt <= '0;
        ready        <= 1'b0;
        blocks_left  <= '0;
        clr_overflow <= 1'b0;
      end else begin
        if (state != ST_INIT) ready <= 1'b1;
        if (push_ok)  fifo_wr <= fifo_wr + 2'd1;
        if (fifo_pop) fifo_rd <= fifo_rd + 2'd1;
        fifo_cnt <= fifo_cnt + 3'(push_ok) - 3'(fifo_pop);
        if (drop) clr_overflow <= 1'b1;
      end
    end
  end

endmodule
